// File: rtl/div_int_hs_if.sv
// Valid/ready bundle for div_int_hs: operand channel in, result channel out.
// The master side presents operands and consumes results; the divider is the slave.
interface div_int_hs_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic             signed_mode;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;
  logic             dbz;
  logic             ovf;

  modport master (
    output in_valid, signed_mode, x, y, out_ready,
    input  in_ready, out_valid, q, r, dbz, ovf
  );

  modport slave (
    input  in_valid, signed_mode, x, y, out_ready,
    output in_ready, out_valid, q, r, dbz, ovf
  );
endinterface

// File: rtl/div_int_hs.sv
// Iterative restoring integer divider (signed/unsigned) with valid/ready handshakes.
// One quotient bit per cycle on operand magnitudes; signs are applied in a final fix-up cycle.
module div_int_hs #(
  parameter int WIDTH = 8
) (
  input logic         clk,
  input logic         rst,
  div_int_hs_if.slave bus
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1'b1);
  localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] dvd_r;
  logic [WIDTH-1:0] dvs_r;
  logic [WIDTH-1:0] acc_r;
  logic             sign_q_r;
  logic             sign_rem_r;
  logic             out_valid_r;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] r_r;
  logic             dbz_r;
  logic             ovf_r;

  logic [WIDTH:0]   acc_shift_s;
  logic [WIDTH:0]   diff_s;
  logic [WIDTH-1:0] acc_next_s;
  logic [WIDTH-1:0] dvd_next_s;
  logic             qbit_s;
  logic             sx_s;
  logic             sy_s;
  logic             min_ovf_s;

  // WIDTH-bit two's-complement negation when neg is set; -MIN_NEG wraps back to MIN_NEG.
  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
    logic [WIDTH-1:0] res;
    if (neg) begin
      res = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      res = v;
    end
    return res;
  endfunction

  // Operand sign decode at the input port and the one restoring shift-subtract step.
  always_comb begin
    sx_s        = bus.signed_mode & bus.x[WIDTH-1];
    sy_s        = bus.signed_mode & bus.y[WIDTH-1];
    min_ovf_s   = bus.signed_mode && (bus.x == MIN_NEG) && (bus.y == ALL_ONES);
    // The accumulator is WIDTH+1 bits only while shifted; the restored value always fits WIDTH.
    acc_shift_s = {acc_r, dvd_r[WIDTH-1]};
    diff_s      = acc_shift_s - {1'b0, dvs_r};
    if (diff_s[WIDTH] == 1'b0) begin
      acc_next_s = diff_s[WIDTH-1:0];
      qbit_s     = 1'b1;
    end else begin
      acc_next_s = acc_shift_s[WIDTH-1:0];
      qbit_s     = 1'b0;
    end
    dvd_next_s  = {dvd_r[WIDTH-2:0], qbit_s};
  end

  // Control FSM and all datapath/result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= {CW{1'b0}};
      dvd_r       <= ZERO;
      dvs_r       <= ZERO;
      acc_r       <= ZERO;
      sign_q_r    <= 1'b0;
      sign_rem_r  <= 1'b0;
      out_valid_r <= 1'b0;
      q_r         <= ZERO;
      r_r         <= ZERO;
      dbz_r       <= 1'b0;
      ovf_r       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.in_valid) begin
            if (bus.y == ZERO) begin
              q_r         <= ALL_ONES;
              r_r         <= bus.x;
              dbz_r       <= 1'b1;
              ovf_r       <= 1'b0;
              out_valid_r <= 1'b1;
              state_r     <= DONE;
            end else if (min_ovf_s) begin
              q_r         <= MIN_NEG;
              r_r         <= ZERO;
              dbz_r       <= 1'b0;
              ovf_r       <= 1'b1;
              out_valid_r <= 1'b1;
              state_r     <= DONE;
            end else begin
              dvd_r      <= cond_neg(bus.x, sx_s);
              dvs_r      <= cond_neg(bus.y, sy_s);
              acc_r      <= ZERO;
              cnt_r      <= {CW{1'b0}};
              sign_q_r   <= sx_s ^ sy_s;
              sign_rem_r <= sx_s;
              dbz_r      <= 1'b0;
              ovf_r      <= 1'b0;
              state_r    <= CALC;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        CALC: begin
          acc_r <= acc_next_s;
          dvd_r <= dvd_next_s;
          if (cnt_r == CNT_LAST) begin
            cnt_r   <= {CW{1'b0}};
            state_r <= FIX;
          end else begin
            cnt_r   <= cnt_r + CNT_ONE;
          end
        end
        FIX: begin
          q_r         <= cond_neg(dvd_r, sign_q_r);
          r_r         <= cond_neg(acc_r, sign_rem_r);
          out_valid_r <= 1'b1;
          state_r     <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            state_r     <= IDLE;
          end else begin
            state_r     <= DONE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = (state_r == IDLE);
  assign bus.out_valid = out_valid_r;
  assign bus.q         = q_r;
  assign bus.r         = r_r;
  assign bus.dbz       = dbz_r;
  assign bus.ovf       = ovf_r;
endmodule

// File: tb/tb_div_int_hs.sv
// Directed bench for div_int_hs (WIDTH=8): hand-computed quotient/remainder/flag vectors,
// latency, backpressure and mid-operation reset, checked with immediate assertions.
module tb_div_int_hs;
  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   lat;
  int   guard;
  logic seen_valid;

  div_int_hs_if #(.WIDTH(8)) bus ();

  div_int_hs #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // lat = clock edges after the accept edge until out_valid is seen (0 = visible right after accept).
  task automatic run_op(input logic sm, input logic [7:0] xv, input logic [7:0] yv, output int l);
    int g;
    g = 0;
    while (!bus.in_ready && g < 40) begin
      tick();
      g++;
    end
    check("in_ready_before_accept", {31'd0, bus.in_ready}, 32'd1);
    bus.in_valid    = 1'b1;
    bus.signed_mode = sm;
    bus.x           = xv;
    bus.y           = yv;
    tick();
    bus.in_valid = 1'b0;
    l = 0;
    while (!bus.out_valid && l < 40) begin
      tick();
      l++;
    end
  endtask

  task automatic expect_res(input string tag, input logic [7:0] eq, input logic [7:0] er,
                            input logic edbz, input logic eovf, input int elat, input int l);
    check({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
    check({tag, "_q"}, {24'd0, bus.q}, {24'd0, eq});
    check({tag, "_r"}, {24'd0, bus.r}, {24'd0, er});
    check({tag, "_dbz"}, {31'd0, bus.dbz}, {31'd0, edbz});
    check({tag, "_ovf"}, {31'd0, bus.ovf}, {31'd0, eovf});
    check({tag, "_lat"}, l, elat);
  endtask

  task automatic take(input string tag);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check({tag, "_take_valid"}, {31'd0, bus.out_valid}, 32'd0);
    check({tag, "_take_ready"}, {31'd0, bus.in_ready}, 32'd1);
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    rst             = 1'b1;
    bus.in_valid    = 1'b0;
    bus.signed_mode = 1'b0;
    bus.x           = 8'h00;
    bus.y           = 8'h00;
    bus.out_ready   = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("rst_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_ready", {31'd0, bus.in_ready}, 32'd1);
    check("rst_q", {24'd0, bus.q}, 32'd0);
    check("rst_r", {24'd0, bus.r}, 32'd0);
    check("rst_dbz", {31'd0, bus.dbz}, 32'd0);
    check("rst_ovf", {31'd0, bus.ovf}, 32'd0);

    // Unsigned 200/7 = 28 r 4, WIDTH+1 edges of latency.
    run_op(1'b0, 8'd200, 8'd7, lat);
    expect_res("u200_7", 8'h1C, 8'h04, 1'b0, 1'b0, 9, lat);
    take("u200_7");

    // Signed: truncation toward zero, remainder follows the dividend.
    run_op(1'b1, 8'hF9, 8'h02, lat);
    expect_res("s_m7_2", 8'hFD, 8'hFF, 1'b0, 1'b0, 9, lat);
    take("s_m7_2");
    run_op(1'b1, 8'h07, 8'hFE, lat);
    expect_res("s_7_m2", 8'hFD, 8'h01, 1'b0, 1'b0, 9, lat);
    take("s_7_m2");
    run_op(1'b1, 8'h80, 8'h03, lat);
    expect_res("s_m128_3", 8'hD6, 8'hFE, 1'b0, 1'b0, 9, lat);
    take("s_m128_3");
    run_op(1'b1, 8'h9C, 8'hF9, lat);
    expect_res("s_m100_m7", 8'h0E, 8'hFE, 1'b0, 1'b0, 9, lat);
    take("s_m100_m7");

    // Signed overflow special case, then the same bits unsigned.
    run_op(1'b1, 8'h80, 8'hFF, lat);
    expect_res("s_ovf", 8'h80, 8'h00, 1'b0, 1'b1, 0, lat);
    take("s_ovf");
    run_op(1'b0, 8'h80, 8'hFF, lat);
    expect_res("u_128_255", 8'h00, 8'h80, 1'b0, 1'b0, 9, lat);
    take("u_128_255");

    // Divide by zero in both modes; flag clears on the next operation.
    run_op(1'b1, 8'h5A, 8'h00, lat);
    expect_res("s_dbz", 8'hFF, 8'h5A, 1'b1, 1'b0, 0, lat);
    take("s_dbz");
    run_op(1'b0, 8'h5A, 8'h00, lat);
    expect_res("u_dbz", 8'hFF, 8'h5A, 1'b1, 1'b0, 0, lat);
    take("u_dbz");
    run_op(1'b0, 8'd10, 8'd3, lat);
    expect_res("u10_3", 8'h03, 8'h01, 1'b0, 1'b0, 9, lat);
    take("u10_3");

    // Backpressure: results hold, busy in_valid pulse is dropped.
    run_op(1'b0, 8'd100, 8'd9, lat);
    expect_res("bp", 8'h0B, 8'h01, 1'b0, 1'b0, 9, lat);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        bus.in_valid = 1'b1;
        bus.x        = 8'd50;
        bus.y        = 8'd0;
      end else begin
        bus.in_valid = 1'b0;
      end
      tick();
      check("bp_hold_valid", {31'd0, bus.out_valid}, 32'd1);
      check("bp_hold_q", {24'd0, bus.q}, 32'h0B);
      check("bp_hold_r", {24'd0, bus.r}, 32'h01);
      check("bp_hold_dbz", {31'd0, bus.dbz}, 32'd0);
      check("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
    end
    bus.in_valid = 1'b0;
    take("bp");
    tick();
    tick();
    check("bp_no_ghost", {31'd0, bus.out_valid}, 32'd0);

    // Reset at CALC step 3 discards the operation.
    bus.in_valid    = 1'b1;
    bus.signed_mode = 1'b0;
    bus.x           = 8'd77;
    bus.y           = 8'd5;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_valid", {31'd0, bus.out_valid}, 32'd0);
    check("mid_rst_ready", {31'd0, bus.in_ready}, 32'd1);
    seen_valid = 1'b0;
    for (guard = 0; guard < 12; guard++) begin
      tick();
      seen_valid = seen_valid | bus.out_valid;
    end
    check("mid_rst_no_result", {31'd0, seen_valid}, 32'd0);
    run_op(1'b0, 8'd77, 8'd5, lat);
    expect_res("after_rst", 8'h0F, 8'h02, 1'b0, 1'b0, 9, lat);
    take("after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/div_int_hs.md
Name: div_int_hs

Overview:
- Parametrised successor to the team's iterative restoring integer divider.
- Adds signed/unsigned mode per operation, valid/ready handshakes on input and output, synchronous reset, signed-overflow detection and a fixed divide-by-zero result.
- Used by datapath blocks that need a small, multi-cycle divider with backpressure.

Parameters:
WIDTH, 8, operand/result width in bits (>=2).

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  synchronous reset, active-high.
in_valid  input  1  operands presented.
in_ready  output  1  block can accept operands.
signed_mode  input  1  1 = two's-complement, 0 = unsigned; sampled at accept.
x  input  WIDTH  dividend.
y  input  WIDTH  divisor.
out_valid  output  1  results valid; held until taken.
out_ready  input  1  consumer accepts results.
q  output  WIDTH  quotient.
r  output  WIDTH  remainder.
dbz  output  1  divide-by-zero flag, qualified by out_valid.
ovf  output  1  signed overflow flag, qualified by out_valid.

Behaviour:
- Reset
  - Synchronous, active-high.
  - State goes to IDLE. out_valid=0, q=0, r=0, dbz=0, ovf=0, iteration counter=0.
  - in_ready=1 in the cycle after reset is released.
  - Reset mid-operation discards the operation with no output.
- States: IDLE, CALC, FIX, DONE. in_ready = (state==IDLE), combinational from state.
- Accept: a transfer occurs on a rising edge where in_valid && in_ready. It captures x, y and signed_mode.
- Special cases at accept (IDLE -> DONE directly; out_valid visible the next cycle):
  - y==0: q = all ones, r = x, dbz=1, ovf=0. This holds in both modes.
  - signed_mode && x==2^(WIDTH-1) && y==all ones: q = 2^(WIDTH-1), r=0, ovf=1, dbz=0.
- Normal accept (IDLE -> CALC):
  - Latch magnitudes |x| and |y| as WIDTH-bit unsigned. |-2^(WIDTH-1)| = 2^(WIDTH-1) fits unsigned.
  - Latch sign_q = sx^sy and sign_r = sx, where sx/sy are operand MSBs when signed_mode=1, else 0.
  - Clear the WIDTH+1-bit accumulator and the counter.
- CALC:
  - One restoring step per cycle: shift-subtract with a WIDTH+1-bit accumulator.
  - Exactly WIDTH cycles; counter runs 0..WIDTH-1.
  - On the last step, go to FIX.
- FIX (one cycle):
  - q = sign_q ? -qmag : qmag; r = sign_r ? -rmag : rmag.
  - Negation is WIDTH-bit two's complement.
  - Quotient truncates toward zero; remainder takes the dividend's sign (or is 0).
  - Set out_valid; go to DONE.
- DONE:
  - q, r, dbz and ovf are stable while out_valid=1 && out_ready=0.
  - On out_valid && out_ready at an edge: out_valid=0, go to IDLE. in_ready=1 the following cycle; no same-cycle overlap.
  - dbz/ovf are cleared when the next operation is accepted.
- Latency:
  - Normal: accept at edge N gives out_valid high after edge N+WIDTH+1.
  - Special case: out_valid high after edge N.
- Inputs are ignored outside IDLE. in_valid while busy is a no-op and is not queued.
- out_ready=1 while out_valid=0 has no effect.
- Invariant: when out_valid && !dbz && !ovf, x == q*y + r and |r| < |y| (interpreted in the active mode).

Test Plan:
1. WIDTH=8, unsigned, x=200, y=7, out_ready=1 -> q=28 (0x1C), r=4, dbz=0, ovf=0; out_valid exactly 9 cycles after the accept edge.
2. Signed x=0xF9 (-7), y=0x02 -> q=0xFD (-3), r=0xFF (-1). Also x=0x07, y=0xFE -> q=0xFD, r=0x01. Also x=0x80 (-128), y=0x03 -> q=0xD6 (-42), r=0xFE (-2).
3. Signed x=0x80, y=0xFF -> q=0x80, r=0x00, ovf=1, out_valid one cycle after accept. The same operands unsigned -> q=0x00, r=0x80, ovf=0.
4. y=0, x=0x5A, both modes -> q=0xFF, r=0x5A, dbz=1, 1-cycle latency. A following 10/3 op -> dbz=0, q=3, r=1.
5. Backpressure: hold out_ready=0 for 5 cycles after out_valid -> q/r/flags stable, in_ready=0, and an extra in_valid pulse is ignored. Raise out_ready -> out_valid drops and in_ready=1 the next cycle.
6. Assert rst for 1 cycle at CALC step 3 -> out_valid=0, in_ready=1 after release, no spurious result. A new op then completes correctly.
7. Random regression: 10k random operands and modes checked against a signed/unsigned reference model.
